// File: rtl/bf_pkg.sv
// Shared BF machine definitions: opcodes and loop-scanner state encoding.
// Used by bf_loop_scanner (optional BF_SCAN_NULL_STOP_EN uses OP_NULL).
package bf_pkg;

  localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;
  localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;
  localparam logic [7:0] OP_NULL       = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } scan_state_t;

endpackage

// File: rtl/bf_loop_scanner.sv
// Bracket-matching sequencer: walks the PC to the matching '[' / ']'.
// Optional: define BF_SCAN_NULL_STOP_EN to treat 0x00 as end-of-program.
import bf_pkg::*;

module bf_loop_scanner #(
  parameter int              DEPTH_W = 8,
  parameter int              PC_W    = 16,
  parameter logic [PC_W-1:0] PC_LAST = 16'hFFFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            dir,
  input  logic [PC_W-1:0] pc,
  input  logic [7:0]      instr,
  output logic            pc_step,
  output logic            PCDecInc,
  output logic            busy,
  output logic            done,
  output logic            err
);

  scan_state_t        r_state;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_dir;

  scan_state_t        w_next;
  logic [DEPTH_W-1:0] w_depth_nxt;
  logic               w_at_edge;
  logic               w_same;
  logic               w_opp;
  logic               w_null;

  // Bracket classification relative to the scan direction
  always_comb begin
    w_at_edge = r_dir ? (pc == '0) : (pc == PC_LAST);
    w_same    = r_dir ? (instr == OP_LOOP_CLOSE)
                      : (instr == OP_LOOP_OPEN);
    w_opp     = r_dir ? (instr == OP_LOOP_OPEN)
                      : (instr == OP_LOOP_CLOSE);
`ifdef BF_SCAN_NULL_STOP_EN
    w_null    = (instr == OP_NULL);
`else
    w_null    = 1'b0;
`endif
  end

  // Next state, depth update and outputs
  always_comb begin
    w_next      = r_state;
    w_depth_nxt = r_depth;
    pc_step     = 1'b0;
    PCDecInc    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next      = STEP;
          w_depth_nxt = DEPTH_W'(1);
        end
      end
      STEP: begin
        busy = 1'b1;
        if (w_at_edge) begin
          err    = 1'b1;
          w_next = FIN;
        end else begin
          pc_step  = 1'b1;
          PCDecInc = r_dir;
          w_next   = CHECK;
        end
      end
      CHECK: begin
        busy   = 1'b1;
        w_next = STEP;
        unique case (1'b1)
          w_null: begin
            err    = 1'b1;
            w_next = FIN;
          end
          w_same: begin
            if (r_depth == '1) begin
              err    = 1'b1;
              w_next = FIN;
            end else begin
              w_depth_nxt = r_depth + DEPTH_W'(1);
            end
          end
          w_opp: begin
            w_depth_nxt = r_depth - DEPTH_W'(1);
            if (r_depth == DEPTH_W'(1)) begin
              done   = 1'b1;
              w_next = FIN;
            end
          end
          default: begin
            w_next = STEP;
          end
        endcase
      end
      FIN: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State, depth and latched direction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_depth <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_depth <= w_depth_nxt;
      if (r_state == IDLE && start) begin
        r_dir <= dir;
      end
    end
  end

endmodule

// File: tb/tb_bf_loop_scanner.sv
// Directed bench for bf_loop_scanner with a PC register and program ROM.
// Expectations follow BF_SCAN_NULL_STOP_EN when defined.
`timescale 1ns/1ps

module tb_bf_loop_scanner;

  logic        clk;
  logic        reset;
  logic        start;
  logic        dir;
  logic [15:0] pc;
  logic [7:0]  instr;
  logic        pc_step;
  logic        PCDecInc;
  logic        busy;
  logic        done;
  logic        err;

  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [7:0]  mem [0:65535];

  int n_cmp;
  int n_bad;

  bf_loop_scanner #(
    .DEPTH_W(2),
    .PC_W   (16),
    .PC_LAST(16'hFFFF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dir     (dir),
    .pc      (pc),
    .instr   (instr),
    .pc_step (pc_step),
    .PCDecInc(PCDecInc),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register fed by the PC ALU
  always @(posedge clk) begin
    if (pc_load)
      pc <= pc_load_val;
    else if (pc_step)
      pc <= PCDecInc ? pc - 16'd1 : pc + 16'd1;
  end

  assign instr = mem[pc];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 65536; i++) mem[i] = v;
  endtask

  task automatic load_pc(input logic [15:0] v);
    @(negedge clk);
    pc_load = 1'b1;
    pc_load_val = v;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  // Start a scan and watch it; mid>0 pulses a conflicting start that cycle
  task automatic run_scan(input logic [15:0] spc,
                          input logic sdir,
                          input int mid,
                          output int lat,
                          output int steps,
                          output logic gdone,
                          output logic gerr,
                          output logic bad,
                          output logic fin_busy);
    lat = -1;
    steps = 0;
    gdone = 1'b0;
    gerr = 1'b0;
    bad = 1'b0;
    load_pc(spc);
    start = 1'b1;
    dir = sdir;
    @(negedge clk);
    start = 1'b0;
    dir = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (pc_step) begin
        steps++;
        if (PCDecInc !== sdir) bad = 1'b1;
      end
      if (done && err) bad = 1'b1;
      if (!busy) bad = 1'b1;
      if (k == mid) begin
        start = 1'b1;
        dir = ~sdir;
      end else begin
        start = 1'b0;
        dir = 1'b0;
      end
      if (done || err) begin
        gdone = done;
        gerr = err;
        lat = k + 1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    dir = 1'b0;
    @(negedge clk);
    fin_busy = busy;
    if (done || err || pc_step) bad = 1'b1;
    @(negedge clk);
  endtask

  int   lat;
  int   steps;
  logic gd;
  logic ge;
  logic bad;
  logic fb;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    start = 1'b0;
    dir = 1'b0;
    pc_load = 1'b1;
    pc_load_val = 16'd0;
    fill(8'h2B);
    repeat (3) @(negedge clk);
    chk("rst_outs", {27'd0, pc_step, PCDecInc, busy, done, err}, 32'd0);
    reset = 1'b0;
    pc_load = 1'b0;

    // Forward flat "[+-]"
    mem[0] = 8'h5B; mem[1] = 8'h2B; mem[2] = 8'h2D; mem[3] = 8'h5D;
    run_scan(16'd0, 1'b0, 0, lat, steps, gd, ge, bad, fb);
    chk("fwd_lat", lat, 7);
    chk("fwd_steps", steps, 3);
    chk("fwd_done", {31'd0, gd}, 1);
    chk("fwd_err", {31'd0, ge}, 0);
    chk("fwd_pc", {16'd0, pc}, 3);
    chk("fwd_proto", {31'd0, bad}, 0);
    chk("fwd_finbusy", {31'd0, fb}, 0);

    // Backward nested "[[-]>]"
    fill(8'h2B);
    mem[0] = 8'h5B; mem[1] = 8'h5B; mem[2] = 8'h2D;
    mem[3] = 8'h5D; mem[4] = 8'h3E; mem[5] = 8'h5D;
    run_scan(16'd5, 1'b1, 0, lat, steps, gd, ge, bad, fb);
    chk("bwd_lat", lat, 11);
    chk("bwd_steps", steps, 5);
    chk("bwd_done", {31'd0, gd}, 1);
    chk("bwd_err", {31'd0, ge}, 0);
    chk("bwd_pc", {16'd0, pc}, 0);
    chk("bwd_proto", {31'd0, bad}, 0);

    // Unmatched forward near the top of memory
    fill(8'h2B);
    mem[16'hFFFD] = 8'h5B;
    run_scan(16'hFFFD, 1'b0, 0, lat, steps, gd, ge, bad, fb);
    chk("unm_lat", lat, 6);
    chk("unm_steps", steps, 2);
    chk("unm_err", {31'd0, ge}, 1);
    chk("unm_done", {31'd0, gd}, 0);
    chk("unm_pc", {16'd0, pc}, 32'h0000FFFF);
    chk("unm_proto", {31'd0, bad}, 0);

    // Unmatched backward at address 0: immediate boundary error
    fill(8'h2B);
    mem[0] = 8'h5D;
    run_scan(16'd0, 1'b1, 0, lat, steps, gd, ge, bad, fb);
    chk("bnd0_lat", lat, 2);
    chk("bnd0_steps", steps, 0);
    chk("bnd0_err", {31'd0, ge}, 1);
    chk("bnd0_pc", {16'd0, pc}, 0);

    // Depth overflow with a 2-bit counter: "[[[["
    fill(8'h2B);
    mem[0] = 8'h5B; mem[1] = 8'h5B; mem[2] = 8'h5B; mem[3] = 8'h5B;
    run_scan(16'd0, 1'b0, 0, lat, steps, gd, ge, bad, fb);
    chk("ovf_lat", lat, 7);
    chk("ovf_steps", steps, 3);
    chk("ovf_err", {31'd0, ge}, 1);
    chk("ovf_done", {31'd0, gd}, 0);
    chk("ovf_pc", {16'd0, pc}, 3);
    chk("ovf_finbusy", {31'd0, fb}, 0);
    chk("ovf_proto", {31'd0, bad}, 0);

    // Reset four cycles into a scan
    fill(8'h2B);
    mem[0] = 8'h5B; mem[1] = 8'h2B; mem[2] = 8'h2D; mem[3] = 8'h5D;
    load_pc(16'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_outs", {27'd0, pc_step, PCDecInc, busy, done, err}, 0);
    chk("mrst_pc", {16'd0, pc}, 2);
    @(negedge clk);
    chk("mrst_idle", {27'd0, pc_step, PCDecInc, busy, done, err}, 0);

    // Rescan with a conflicting start while busy
    run_scan(16'd0, 1'b0, 3, lat, steps, gd, ge, bad, fb);
    chk("rs_lat", lat, 7);
    chk("rs_steps", steps, 3);
    chk("rs_done", {31'd0, gd}, 1);
    chk("rs_pc", {16'd0, pc}, 3);
    chk("rs_proto", {31'd0, bad}, 0);

    // Null byte inside a loop: "[+\0-]"
    fill(8'h2B);
    mem[0] = 8'h5B; mem[1] = 8'h2B; mem[2] = 8'h00;
    mem[3] = 8'h2D; mem[4] = 8'h5D;
    run_scan(16'd0, 1'b0, 0, lat, steps, gd, ge, bad, fb);
`ifdef BF_SCAN_NULL_STOP_EN
    chk("nul_lat", lat, 5);
    chk("nul_err", {31'd0, ge}, 1);
    chk("nul_done", {31'd0, gd}, 0);
    chk("nul_pc", {16'd0, pc}, 2);
`else
    chk("nul_lat", lat, 9);
    chk("nul_err", {31'd0, ge}, 0);
    chk("nul_done", {31'd0, gd}, 1);
    chk("nul_pc", {16'd0, pc}, 4);
`endif
    chk("nul_proto", {31'd0, bad}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
